// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath (shared memory, IR/old_PC/MDR/A/B/ALUOut).
// Define ILLEGAL_TRAP_EN to trap unknown opcodes in a HALT state that drives the illegal output.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opc,
  input  logic [2:0]         f3,
  input  logic               zero,
  input  logic               neg,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         imm_src,
  output logic [1:0]         alu_op,
`ifdef ILLEGAL_TRAP_EN
  output logic               illegal,
`endif
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    JALR_ADR  = 4'd11,
    JALR_JMP  = 4'd12,
    LUI       = 4'd13,
    HALT      = 4'd14
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [1:0] alu_op;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl_reg;
  logic   branch_cond;
  logic   branch_take;

  // Control word for a state; registering ctrl_of(state_next) keeps every output glitch-free.
  function automatic ctrl_t ctrl_of(input state_t s, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.imm_src   = 3'b010;
      end
      MEM_ADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.imm_src   = (op == OP_SW) ? 3'b001 : 3'b000;
      end
      MEM_READ: c.adr_src = 1'b1;
      MEM_WB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      EXEC_R: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      EXEC_I: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b11;
      end
      ALU_WB: c.reg_write = 1'b1;
      BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
      end
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_write  = 1'b1;
        c.imm_src   = 3'b100;
      end
      JALR_ADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      JALR_JMP: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_write  = 1'b1;
      end
      LUI: begin
        c.imm_src    = 3'b011;
        c.result_src = 2'b11;
        c.reg_write  = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      HALT: c.illegal = 1'b1;
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (opc)
          OP_LW, OP_SW: state_next = MEM_ADR;
          OP_R:         state_next = EXEC_R;
          OP_I:         state_next = EXEC_I;
          OP_B:         state_next = BRANCH;
          OP_JAL:       state_next = JAL;
          OP_JALR:      state_next = JALR_ADR;
          OP_LUI:       state_next = LUI;
`ifdef ILLEGAL_TRAP_EN
          default:      state_next = HALT;
`else
          default:      state_next = FETCH;
`endif
        endcase
      end
      MEM_ADR:  state_next = (opc == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ: state_next = MEM_WB;
      EXEC_R:   state_next = ALU_WB;
      EXEC_I:   state_next = ALU_WB;
      JAL:      state_next = ALU_WB;
      JALR_ADR: state_next = JALR_JMP;
      JALR_JMP: state_next = ALU_WB;
`ifdef ILLEGAL_TRAP_EN
      HALT:     state_next = HALT;
`endif
      default:  state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
      ctrl_reg  <= ctrl_of(FETCH, opc);
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_of(state_next, opc);
    end
  end

  // The branch decision needs this cycle's ALU flags, so it cannot be registered.
  always_comb begin
    branch_cond = 1'b0;
    case (f3)
      3'b000:  branch_cond = zero;
      3'b001:  branch_cond = ~zero;
      3'b100:  branch_cond = neg;
      3'b101:  branch_cond = ~neg | zero;
      default: branch_cond = 1'b0;
    endcase
  end

  assign branch_take = (state_reg == BRANCH) && branch_cond;

  assign pc_write   = (ctrl_reg.pc_write | branch_take) & ~rst;
  assign mem_write  = ctrl_reg.mem_write & ~rst;
  assign ir_write   = ctrl_reg.ir_write & ~rst;
  assign reg_write  = ctrl_reg.reg_write & ~rst;
  assign adr_src    = ctrl_reg.adr_src;
  assign result_src = ctrl_reg.result_src;
  assign alu_src_a  = ctrl_reg.alu_src_a;
  assign alu_src_b  = ctrl_reg.alu_src_b;
  assign imm_src    = ctrl_reg.imm_src;
  assign alu_op     = ctrl_reg.alu_op;
`ifdef ILLEGAL_TRAP_EN
  assign illegal    = ctrl_reg.illegal;
`endif
  assign state      = STATE_W'(state_reg);

endmodule
